// File: rtl/score_keeper.sv
// Score keeper: turns miss pulses into scores, goal/win pulses and serve gating.
// Latency 1 cycle (all outputs registered); no backpressure. Optional: SCORE_KEEPER_WIN_BY_TWO_EN.
module score_keeper #(
    parameter int WIN_SCORE      = 7,
    parameter int SCORE_W        = 4,
    parameter int HOLDOFF_CYCLES = 120,
    parameter int HOLDOFF_W      = 8
) (
    input  logic               BALL_CLOCK,
    input  logic               RESET_N,
    input  logic               miss_player_1,
    input  logic               miss_player_2,
    input  logic               new_game,
    output logic               goal_player_1,
    output logic               goal_player_2,
    output logic               win_player_1,
    output logic               win_player_2,
    output logic [SCORE_W-1:0] score_1,
    output logic [SCORE_W-1:0] score_2,
    output logic               serve_enable,
    output logic               game_over
);

    typedef enum logic [1:0] {PLAY, HOLD, OVER} state_t;

    localparam logic [SCORE_W-1:0]   SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0]   WIN_VAL   = SCORE_W'(WIN_SCORE);
    localparam logic [HOLDOFF_W-1:0] HOLD_LOAD = HOLDOFF_W'(HOLDOFF_CYCLES - 1);

    state_t               state, state_nx;
    logic [HOLDOFF_W-1:0] holdoff, holdoff_nx;
    logic [SCORE_W-1:0]   score_1_nx, score_2_nx, inc_1, inc_2;
    logic                 goal_1_nx, goal_2_nx, win_1_nx, win_2_nx;
    logic                 wins_1, wins_2;

    assign inc_1 = (score_1 == SCORE_MAX) ? SCORE_MAX : score_1 + 1'b1;
    assign inc_2 = (score_2 == SCORE_MAX) ? SCORE_MAX : score_2 + 1'b1;

`ifdef SCORE_KEEPER_WIN_BY_TWO_EN
    // A point taken at saturation wins outright so the game cannot stall.
    assign wins_1 = (score_1 == SCORE_MAX) ||
                    ((inc_1 >= WIN_VAL) && ({1'b0, inc_1} >= {1'b0, score_2} + (SCORE_W+1)'(2)));
    assign wins_2 = (score_2 == SCORE_MAX) ||
                    ((inc_2 >= WIN_VAL) && ({1'b0, inc_2} >= {1'b0, score_1} + (SCORE_W+1)'(2)));
`else
    assign wins_1 = (inc_1 == WIN_VAL);
    assign wins_2 = (inc_2 == WIN_VAL);
`endif

    always_comb begin
        state_nx   = state;
        holdoff_nx = holdoff;
        score_1_nx = score_1;
        score_2_nx = score_2;
        goal_1_nx  = 1'b0;
        goal_2_nx  = 1'b0;
        win_1_nx   = 1'b0;
        win_2_nx   = 1'b0;
        if (new_game) begin
            // new_game beats any same-cycle miss and cancels a running holdoff.
            state_nx   = PLAY;
            holdoff_nx = '0;
            score_1_nx = '0;
            score_2_nx = '0;
        end else begin
            case (state)
                PLAY: begin
                    if (miss_player_2 && !miss_player_1) begin
                        score_1_nx = inc_1;
                        if (wins_1) begin
                            win_1_nx = 1'b1;
                            state_nx = OVER;
                        end else begin
                            goal_1_nx  = 1'b1;
                            holdoff_nx = HOLD_LOAD;
                            state_nx   = HOLD;
                        end
                    end else if (miss_player_1 && !miss_player_2) begin
                        score_2_nx = inc_2;
                        if (wins_2) begin
                            win_2_nx = 1'b1;
                            state_nx = OVER;
                        end else begin
                            goal_2_nx  = 1'b1;
                            holdoff_nx = HOLD_LOAD;
                            state_nx   = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (holdoff == '0) state_nx = PLAY;
                    else               holdoff_nx = holdoff - 1'b1;
                end
                OVER:    state_nx = OVER;
                default: state_nx = PLAY;
            endcase
        end
    end

    always_ff @(posedge BALL_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= PLAY;
            holdoff       <= '0;
            score_1       <= '0;
            score_2       <= '0;
            goal_player_1 <= 1'b0;
            goal_player_2 <= 1'b0;
            win_player_1  <= 1'b0;
            win_player_2  <= 1'b0;
            serve_enable  <= 1'b1;
            game_over     <= 1'b0;
        end else begin
            state         <= state_nx;
            holdoff       <= holdoff_nx;
            score_1       <= score_1_nx;
            score_2       <= score_2_nx;
            goal_player_1 <= goal_1_nx;
            goal_player_2 <= goal_2_nx;
            win_player_1  <= win_1_nx;
            win_player_2  <= win_2_nx;
            serve_enable  <= (state_nx == PLAY);
            game_over     <= (state_nx == OVER);
        end
    end

endmodule
